// File: rtl/round_ctrl_if.sv
// ---------------------------------------------------------------------------
// round_ctrl_if
// Bundles the control/status signals between the Midori64 TI round
// controller and its host / datapath.
//
//   start      host -> ctrl   begin one encryption (only honoured when idle)
//   busy       ctrl -> host   controller is not idle
//   done       ctrl -> host   one-cycle pulse, ciphertext valid in state reg
//   load_en    ctrl -> dp     state register captures plaintext ^ WK
//   round_en   ctrl -> dp     state register captures round output
//   final_en   ctrl -> dp     state register captures final S-box ^ WK
//   round_idx  ctrl -> dp     current keyed round number
//   stage      ctrl -> dp     sub-cycle inside the TI S-box pipeline
//   sel        ctrl -> dp     round-key select (0 = k0, 1 = k1)
//   constant   ctrl -> dp     16-bit round constant, one bit per nibble LSB
//
// slave  : the controller side (receives start, drives everything else)
// master : the host/datapath side
// ---------------------------------------------------------------------------
interface round_ctrl_if #(
    parameter int SW = 2
);
    logic          start;
    logic          busy;
    logic          done;
    logic          load_en;
    logic          round_en;
    logic          final_en;
    logic [3:0]    round_idx;
    logic [SW-1:0] stage;
    logic          sel;
    logic [15:0]   constant;

    modport slave (
        input  start,
        output busy, done, load_en, round_en, final_en,
        output round_idx, stage, sel, constant
    );

    modport master (
        output start,
        input  busy, done, load_en, round_en, final_en,
        input  round_idx, stage, sel, constant
    );
endinterface

// File: rtl/round_ctrl.sv
// ---------------------------------------------------------------------------
// round_ctrl
// Sequencer for the Midori64 threshold-implementation core. Walks through
// input whitening (LOAD), ROUNDS keyed rounds of CPR cycles each (ROUND),
// the final S-box layer (FINAL, CPR cycles) and a one-cycle DONE.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high; aborts any operation in flight
//   bus  : round_ctrl_if.slave (start in; status, strobes, round info out)
//
// Every output is decoded from the registered state, round counter and
// stage counter only, so there is no combinational path from start.
// ---------------------------------------------------------------------------
module round_ctrl #(
    parameter int                    ROUNDS   = 15,
    parameter int                    CPR      = 2,
    parameter int                    SW       = 2,
    // alpha_i lives at [16*i+15 : 16*i]; literal lists alpha_14 first.
    parameter logic [ROUNDS*16-1:0]  RC_TABLE = {
        16'hDF90, 16'hF8CA, 16'h5130, 16'h228E, 16'h7197,
        16'h40B8, 16'h9481, 16'h0BCC, 16'h0266, 16'hD170,
        16'h104F, 16'h6213, 16'hA435, 16'h78C0, 16'h15B3
    }
) (
    input  logic         clk,
    input  logic         rst,
    round_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_t;

    localparam logic [SW-1:0] LAST_STAGE = SW'(CPR - 1);
    localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS - 1);

    state_t        state_q, state_n;
    logic [3:0]    round_q, round_n;
    logic [SW-1:0] stage_q, stage_n;

    // Round-constant ROM lookup; indices beyond ROUNDS-1 never occur.
    function automatic logic [15:0] rc_lookup(input logic [3:0] idx);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < ROUNDS; i++) begin
            if (idx == 4'(i)) begin
                v = RC_TABLE[16*i +: 16];
            end
        end
        return v;
    endfunction

    // State, round and stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            stage_q <= '0;
        end else begin
            state_q <= state_n;
            round_q <= round_n;
            stage_q <= stage_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        round_n = round_q;
        stage_n = stage_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = LOAD;
                end
            end

            LOAD: begin
                state_n = ROUND;
                round_n = 4'd0;
                stage_n = '0;
            end

            ROUND: begin
                if (stage_q == LAST_STAGE) begin
                    stage_n = '0;
                    if (round_q == LAST_ROUND) begin
                        // Counter is cleared here so FINAL/DONE/IDLE read 0.
                        state_n = FINAL;
                        round_n = 4'd0;
                    end else begin
                        round_n = round_q + 4'd1;
                    end
                end else begin
                    stage_n = stage_q + SW'(1);
                end
            end

            FINAL: begin
                if (stage_q == LAST_STAGE) begin
                    state_n = DONE;
                    stage_n = '0;
                end else begin
                    stage_n = stage_q + SW'(1);
                end
            end

            DONE: begin
                // start seen here is not sampled; IDLE re-evaluates it.
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
                round_n = 4'd0;
                stage_n = '0;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.load_en   = 1'b0;
        bus.round_en  = 1'b0;
        bus.final_en  = 1'b0;
        bus.round_idx = round_q;
        bus.stage     = stage_q;
        bus.sel       = 1'b0;
        bus.constant  = 16'h0000;

        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
            end

            LOAD: begin
                bus.busy    = 1'b1;
                bus.load_en = 1'b1;
            end

            ROUND: begin
                bus.busy     = 1'b1;
                bus.round_en = (stage_q == LAST_STAGE);
                // Key select and constant depend only on round_q, so they
                // stay constant across all CPR sub-cycles of the round.
                bus.sel      = round_q[0];
                bus.constant = rc_lookup(round_q);
            end

            FINAL: begin
                bus.busy     = 1'b1;
                bus.final_en = (stage_q == LAST_STAGE);
            end

            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end

            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_round_ctrl
// Two controller instances: default (CPR=2) and a CPR=1 build. Expected
// outputs come from a timeline model: given the number of cycles since an
// accepted start, the position in LOAD/ROUND/FINAL/DONE follows directly
// from the latency arithmetic.
// ---------------------------------------------------------------------------
module tb_round_ctrl;

    localparam int R = 15;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int errors = 0;
    int checks = 0;

    logic [15:0] rc [R] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
        16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
        16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90
    };

    round_ctrl_if #(.SW(2)) ifa ();
    round_ctrl_if #(.SW(1)) ifb ();

    round_ctrl u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    round_ctrl #(.CPR(1), .SW(1)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    // Expected {busy,done,load,round_en,final_en,round_idx[4],stage[2],sel,constant[16]}
    // k = cycles since start was sampled (0 = idle).
    function automatic logic [27:0] mdl(input int k, input int cpr);
        logic b, d, ld, re, fe, sl;
        logic [3:0]  ri;
        logic [1:0]  st;
        logic [15:0] c;
        int r, s;
        b = 0; d = 0; ld = 0; re = 0; fe = 0; sl = 0; ri = 0; st = 0; c = 0;
        if (k == 1) begin
            b = 1; ld = 1;
        end else if (k >= 2 && k <= 1 + R*cpr) begin
            r  = (k - 2) / cpr;
            s  = (k - 2) % cpr;
            b  = 1;
            re = (s == cpr - 1);
            ri = 4'(r);
            st = 2'(s);
            sl = r[0];
            c  = rc[r];
        end else if (k >= 2 + R*cpr && k <= 1 + (R+1)*cpr) begin
            s  = k - 2 - R*cpr;
            b  = 1;
            fe = (s == cpr - 1);
            st = 2'(s);
        end else if (k == 2 + (R+1)*cpr) begin
            b = 1; d = 1;
        end
        return {b, d, ld, re, fe, ri, st, sl, c};
    endfunction

    // Advance the timeline model by one clock edge.
    function automatic int step(input int k, input bit st, input bit rs, input int cpr);
        if (rs) return 0;
        if (k == 0) return st ? 1 : 0;
        if (k == 2 + (R+1)*cpr) return 0;
        return k + 1;
    endfunction

    function automatic logic [27:0] obs_a();
        return {ifa.busy, ifa.done, ifa.load_en, ifa.round_en, ifa.final_en,
                ifa.round_idx, ifa.stage, ifa.sel, ifa.constant};
    endfunction

    function automatic logic [27:0] obs_b();
        return {ifb.busy, ifb.done, ifb.load_en, ifb.round_en, ifb.final_en,
                ifb.round_idx, 1'b0, ifb.stage, ifb.sel, ifb.constant};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; ifa.start = 0; ifb.start = 0;
        tick(); tick();
        checks++;
        if (obs_a() !== 28'h0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=%h", obs_a(), 28'h0);
        end
        checks++;
        if (obs_b() !== 28'h0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=%h", obs_b(), 28'h0);
        end
        rst_a = 0; rst_b = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_a() !== 28'h0) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs_a(), 28'h0);
            end
        end
    endtask

    // Runs one operation on A; extra start pulses at cycles 5 and 20 if ign.
    task automatic run_single(input bit ign, input string name);
        int n_ld, n_re, n_fe, n_dn, k_dn;
        n_ld = 0; n_re = 0; n_fe = 0; n_dn = 0; k_dn = -1;
        ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int k = 1; k <= 40; k++) begin
            checks++;
            if (obs_a() !== mdl(k, 2)) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, obs_a(), mdl(k, 2));
            end
            n_ld += int'(ifa.load_en);
            n_re += int'(ifa.round_en);
            n_fe += int'(ifa.final_en);
            if (ifa.done) begin
                n_dn++;
                k_dn = k;
            end
            ifa.start = ign && (k == 5 || k == 20);
            tick();
        end
        ifa.start = 0;
        checks++;
        if (n_ld !== 1 || n_re !== 15 || n_fe !== 1 || n_dn !== 1) begin
            errors++;
            $display("FAIL %s_counts got ld=%0d re=%0d fe=%0d dn=%0d exp 1/15/1/1",
                     name, n_ld, n_re, n_fe, n_dn);
        end
        checks++;
        if (k_dn !== 34) begin
            errors++;
            $display("FAIL %s_latency got=%0d exp=34", name, k_dn);
        end
    endtask

    task automatic test_single();
        run_single(1'b0, "single");
    endtask

    task automatic test_ignore_start();
        run_single(1'b1, "ignore");
    endtask

    task automatic test_abort();
        int n_dn;
        n_dn = 0;
        ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (obs_a() !== mdl(k, 2)) begin
                errors++;
                $display("FAIL abort_pre cyc=%0d got=%h exp=%h", k, obs_a(), mdl(k, 2));
            end
            if (k == 12) rst_a = 1;
            tick();
        end
        rst_a = 0;
        for (int k = 13; k <= 50; k++) begin
            checks++;
            if (obs_a() !== 28'h0) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got=%h exp=%h", k, obs_a(), 28'h0);
            end
            n_dn += int'(ifa.done);
            tick();
        end
        checks++;
        if (n_dn !== 0) begin
            errors++;
            $display("FAIL abort_done got=%0d exp=0", n_dn);
        end
        run_single(1'b0, "restart");
    endtask

    task automatic test_random();
        int  ka, kb;
        bit  sa, sb, ra, rb;
        ka = 0; kb = 0;
        for (int i = 0; i < 3000; i++) begin
            sa = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 1) == 0);
            ra = ($urandom_range(0, 99) == 0);
            rb = ($urandom_range(0, 99) == 0);
            ifa.start = sa; ifb.start = sb; rst_a = ra; rst_b = rb;
            tick();
            ka = step(ka, sa, ra, 2);
            kb = step(kb, sb, rb, 1);
            checks++;
            if (obs_a() !== mdl(ka, 2)) begin
                errors++;
                $display("FAIL rand_a i=%0d k=%0d got=%h exp=%h", i, ka, obs_a(), mdl(ka, 2));
            end
            checks++;
            if (obs_b() !== mdl(kb, 1)) begin
                errors++;
                $display("FAIL rand_b i=%0d k=%0d got=%h exp=%h", i, kb, obs_b(), mdl(kb, 1));
            end
        end
        ifa.start = 0; ifb.start = 0; rst_a = 0; rst_b = 0;
    endtask

    task automatic test_back_to_back();
        int kb, prev, n_dn;
        kb = 0; prev = -1; n_dn = 0;
        rst_b = 1;
        tick();
        rst_b = 0;
        ifb.start = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            kb = step(kb, 1'b1, 1'b0, 1);
            checks++;
            if (obs_b() !== mdl(kb, 1)) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs_b(), mdl(kb, 1));
            end
            if (ifb.done) begin
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== 19) begin
                        errors++;
                        $display("FAIL b2b_spacing got=%0d exp=19", c - prev);
                    end
                end
                prev = c;
                n_dn++;
            end
        end
        ifb.start = 0;
        checks++;
        if (n_dn < 5) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp>=5", n_dn);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignore_start();
        test_abort();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
